mod_reduce_serial: RTL and testbench
====================================

# mod_reduce_serial

Sequential modular reducer that takes one wide operand and returns `operand mod MODULUS`. It processes CHUNK_W bits per cycle, MSB-first, using a Horner accumulator. It is the parametrised successor of the per-chunk residue LUT blocks in the modular calculator. It sits between the wide-operand producer and the residue-domain arithmetic, with valid/ready on both sides.

## Interface
- MODULUS, 4051: reduction modulus. Elaboration check: 2^(RES_W-1) < MODULUS < 2^RES_W.
- IN_W, 300: operand width in bits.
- CHUNK_W, 6: bits consumed per cycle. Elaboration check: 1 ≤ CHUNK_W ≤ RES_W.
- RES_W, 12: residue width.
- NCHUNK, derived, ceil(IN_W/CHUNK_W): chunk count. The operand is zero-padded at the MSB end to NCHUNK*CHUNK_W bits.
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept an operand.
- in_data  in  IN_W  operand, unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_res  out  RES_W  result, always in 0..MODULUS-1 when out_valid is high.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset puts the FSM in IDLE with acc=0, idx=0, out_valid=0, out_res=0, busy=0 and in_ready=1.
- in_ready = (state==IDLE).
- IDLE to RUN on in_valid && in_ready:
  - Latch the padded operand into a shift register.
  - Clear acc to 0.
  - Set idx = NCHUNK-1.
- RUN, each cycle:
  - Compute acc' = (acc·2^CHUNK_W + chunk[idx]) mod MODULUS.
  - Then idx decrements.
  - After the cycle that processes chunk 0, load out_res from acc', go to DONE and set out_valid=1.
- Per-step reduction, with t = acc·2^CHUNK_W + chunk (width RES_W+CHUNK_W):
  - Split t as hi = t[RES_W+CHUNK_W-1:RES_W] and lo = t[RES_W-1:0].
  - Compute s = fold[hi] + lo, where fold[h] = (h·2^RES_W) mod MODULUS.
  - s < 3·MODULUS is guaranteed by the modulus range check.
  - Apply two cascaded conditional subtracts of MODULUS. Each subtract uses a width of RES_W+2 bits.
- DONE:
  - out_valid and out_res are held stable while out_ready=0.
  - On out_ready=1, go to IDLE and clear out_valid.
  - There is no overlap: a new operand is accepted no earlier than the cycle after the handshake.
- in_data is ignored outside the accept cycle.
- in_valid is ignored in RUN and DONE.
- Reset asserted in any state returns to the reset values at the next edge. Any in-flight operand is discarded, and no out_valid is produced for it.

## Timing
- Accept edge: E0.
- Baseline: chunk k = NCHUNK-1-j is processed at edge E(j+1). out_valid is high from edge E(NCHUNK) onward, which is 50 cycles for the default parameters.
- With early exit enabled (see Configuration): out_valid rises at edge E(max(1, top_nonzero_chunk+1)).
- out_valid to IDLE: in_ready is high in the cycle after the out handshake edge.
- Minimum throughput is one operand per latency+2 cycles with out_ready tied to 1.
- The fold table is combinational. The critical path is table lookup → add → two subtracts.

## Configuration
- MOD_REDUCE_EARLY_EXIT_EN defined:
  - On accept, a leading-zero-chunk detector sets idx to the highest chunk index with a nonzero value. If the operand is zero, idx is set to 0.
  - This skips leading zero chunks.
  - The result is identical to baseline; only latency changes.
- MOD_REDUCE_EARLY_EXIT_EN undefined:
  - idx always starts at NCHUNK-1.
  - Latency is fixed at NCHUNK cycles.
  - The detector is absent.

## Structure
- Package mod_reduce_pkg contains:
  - The function fold_val(h, MODULUS, RES_W), evaluated at elaboration.
  - The state enum (IDLE/RUN/DONE).
  - The localparam helper for ceil division.
- Sub-module mod_fold_lut contains:
  - Parameters MODULUS, RES_W, CHUNK_W.
  - A purely combinational map from hi (CHUNK_W bits) to fold[hi] (RES_W bits).
  - It generalises the fixed per-chunk residue LUTs.
- Top level contains the FSM, operand shift register, accumulator, conditional-subtract chain and optional zero detector.

## Test plan
- in_data=4096 → out_res=45, out_valid after 50 cycles. With EARLY_EXIT, out_valid after 3 cycles.
- in_data=2^24 → 2025. in_data=4051 → 0. in_data=4050 → 4050.
- in_data=0 → out_res=0. Latency is 50 cycles baseline, or 1 cycle with EARLY_EXIT.
- in_data = all-ones (2^300-1) → compare against a reference model. Also run 10k random operands against the reference model (bigint mod), including widths IN_W=301 and CHUNK_W=5.
- Hold out_ready=0 for 7 cycles after out_valid → out_res stable, in_ready=0, and in_valid pulses are ignored. Then release → in_ready=1 on the next cycle.
- Assert rst_n=0 for 1 cycle at RUN cycle 20 → next edge gives IDLE, out_valid=0, out_res=0, in_ready=1. No stale result appears afterwards.

Source files
------------

// File: rtl/mod_reduce_pkg.sv
// Shared types and elaboration-time helpers for the serial modular reducer:
// FSM state enum, ceil-division helper and fold-table generator.
package mod_reduce_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // (h * 2^res_w) mod modulus; only ever evaluated on constants
   function automatic logic [63:0] fold_val(input int unsigned h,
                                            input int unsigned modulus,
                                            input int unsigned res_w);
      logic [63:0] t;
      t = 64'(h) << res_w;
      return t % 64'(modulus);
   endfunction

endpackage

// File: rtl/mod_fold_lut.sv
// Combinational fold table: maps the bits of a Horner step that overflow the
// residue width back into the residue domain, fold[h] = (h * 2^RES_W) mod MODULUS.
module mod_fold_lut
   import mod_reduce_pkg::*;
#(
   parameter int MODULUS = 4051,
   parameter int RES_W   = 12,
   parameter int CHUNK_W = 6
) (
   input  logic [CHUNK_W-1:0] hi_i,
   output logic [RES_W-1:0]   fold_o
);

   logic [RES_W-1:0] fold_tab_w [2**CHUNK_W];

   for (genvar g = 0; g < 2**CHUNK_W; g++) begin : g_tab
      assign fold_tab_w[g] = RES_W'(fold_val(g, MODULUS, RES_W));
   end

   assign fold_o = fold_tab_w[hi_i];

endmodule

// File: rtl/mod_reduce_serial.sv
// Serial MSB-first Horner reducer: operand mod MODULUS, CHUNK_W bits per cycle.
// Optional leading-zero-chunk skip when MOD_REDUCE_EARLY_EXIT_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for an operand, in_ready high
//   RUN   | folding one chunk per cycle, idx counts down to 0
//   DONE  | result presented, held until out_ready
module mod_reduce_serial
   import mod_reduce_pkg::*;
#(
   parameter int MODULUS = 4051,
   parameter int IN_W    = 300,
   parameter int CHUNK_W = 6,
   parameter int RES_W   = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] out_res,
   output logic             busy
);

   localparam int NCHUNK = ceil_div(IN_W, CHUNK_W);
   localparam int PAD_W  = NCHUNK * CHUNK_W;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [RES_W+1:0] MOD_X = (RES_W+2)'(MODULUS);

   if (!(MODULUS > 2**(RES_W-1) && MODULUS < 2**RES_W)) begin : g_bad_modulus
      $error("mod_reduce_serial: MODULUS out of range for RES_W");
   end
   if (CHUNK_W < 1 || CHUNK_W > RES_W) begin : g_bad_chunk
      $error("mod_reduce_serial: CHUNK_W out of range");
   end

   state_t             state_q, state_d;
   logic [RES_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [RES_W-1:0]   res_q, res_d;
   logic [PAD_W-1:0]   opnd_q, opnd_d;

   logic [PAD_W-1:0]         in_pad_w;
   logic [IDX_W-1:0]         start_idx_w;
   logic [CHUNK_W-1:0]       chunk_w;
   logic [RES_W+CHUNK_W-1:0] t_w;
   logic [RES_W-1:0]         fold_w;
   logic [RES_W+1:0]         s_w, s1_w;
   logic [RES_W-1:0]         step_w;

   assign in_pad_w = PAD_W'(in_data);

`ifdef MOD_REDUCE_EARLY_EXIT_EN
   // Highest nonzero chunk; an all-zero operand still takes one step at idx 0
   always_comb begin
      start_idx_w = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (|in_pad_w[k*CHUNK_W +: CHUNK_W]) start_idx_w = IDX_W'(k);
      end
   end
`else
   assign start_idx_w = IDX_W'(NCHUNK - 1);
`endif

   assign chunk_w = opnd_q[idx_q*CHUNK_W +: CHUNK_W];
   assign t_w     = {acc_q, chunk_w};

   mod_fold_lut #(
      .MODULUS (MODULUS),
      .RES_W   (RES_W),
      .CHUNK_W (CHUNK_W)
   ) u_fold (
      .hi_i   (t_w[RES_W+CHUNK_W-1:RES_W]),
      .fold_o (fold_w)
   );

   // fold <= M-1 and lo < 2M, so two conditional subtracts always suffice
   always_comb begin
      s_w    = {2'b00, fold_w} + {2'b00, t_w[RES_W-1:0]};
      s1_w   = (s_w >= MOD_X) ? (s_w - MOD_X) : s_w;
      step_w = (s1_w >= MOD_X) ? RES_W'(s1_w - MOD_X) : RES_W'(s1_w);
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      res_d   = res_q;
      opnd_d  = opnd_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = RUN;
               opnd_d  = in_pad_w;
               acc_d   = '0;
               idx_d   = start_idx_w;
            end
         end
         RUN: begin
            acc_d = step_w;
            if (idx_q == '0) begin
               res_d   = step_w;
               state_d = DONE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
      end
   end

   // Operand store needs no reset: it is only read in RUN, after a load
   always_ff @(posedge clk) begin
      opnd_q <= opnd_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_res   = res_q;

endmodule

// File: tb/tb_mod_reduce_serial.sv
// Self-checking bench for mod_reduce_serial: directed vector table, back-pressure
// and mid-run reset sequences, and random operands against a word-wise bigint model.
module tb_mod_reduce_serial;

   localparam int MODULUS = 4051;
   localparam int IN_W    = 300;
   localparam int CHUNK_W = 6;
   localparam int RES_W   = 12;
   localparam int NCHUNK  = (IN_W + CHUNK_W - 1) / CHUNK_W;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_res;
   logic             busy;

   int total = 0;
   int bad   = 0;

   mod_reduce_serial #(
      .MODULUS (MODULUS),
      .IN_W    (IN_W),
      .CHUNK_W (CHUNK_W),
      .RES_W   (RES_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IN_W-1:0]  data;
      logic [RES_W-1:0] res;
      int               lat_base;
      int               lat_ee;
      string            name;
   } vec_t;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: bigint mod taken 32 bits at a time with plain integer arithmetic
   function automatic longint ref_mod(input logic [IN_W-1:0] x);
      logic [319:0] p;
      longint       r;
      p = 320'(x);
      r = 0;
      for (int w = 9; w >= 0; w--) begin
         r = (r * 64'sh1_0000_0000 + longint'({32'd0, p[w*32 +: 32]})) % MODULUS;
      end
      return r;
   endfunction

   function automatic int ref_lat(input logic [IN_W-1:0] x);
`ifdef MOD_REDUCE_EARLY_EXIT_EN
      int hb;
      hb = -1;
      for (int b = 0; b < IN_W; b++) if (x[b]) hb = b;
      return (hb < 0) ? 1 : (hb / CHUNK_W) + 1;
`else
      return NCHUNK;
`endif
   endfunction

   function automatic int pick_lat(input int lb, input int le);
`ifdef MOD_REDUCE_EARLY_EXIT_EN
      return le;
`else
      return lb;
`endif
   endfunction

   function automatic logic [IN_W-1:0] rand_opnd();
      logic [IN_W-1:0] x;
      for (int w = 0; w < (IN_W + 31) / 32; w++) begin
         for (int b = 0; b < 32; b++) begin
            if (w*32 + b < IN_W) x[w*32 + b] = $urandom_range(0, 1) == 1;
         end
      end
      if ($urandom_range(0, 1) == 1) x = x >> $urandom_range(0, IN_W - 1);
      return x;
   endfunction

   // Called at posedge+1; returns at posedge+1 of the first cycle out_valid is seen
   task automatic run_op(input logic [IN_W-1:0] d, input logic [RES_W-1:0] er,
                         input int el, input string nm);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk({nm, " in_ready"}, longint'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = rand_opnd();
      chk({nm, " busy"}, longint'(busy), 1);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk({nm, " latency"}, longint'(n), longint'(el));
      chk({nm, " out_res"}, longint'(out_res), longint'(er));
   endtask

   initial begin
      vec_t            vecs[7];
      logic [IN_W-1:0] one;
      logic [IN_W-1:0] ones;
      logic [IN_W-1:0] x;
      logic [RES_W-1:0] held;
      int              seen;

      one  = '0;
      one[0] = 1'b1;
      ones = '1;
      vecs[0] = '{one << 12,  12'd45,   50, 3,  "v4096"};
      vecs[1] = '{one << 24,  12'd2025, 50, 5,  "v2pow24"};
      vecs[2] = '{IN_W'(4051), 12'd0,   50, 2,  "v4051"};
      vecs[3] = '{IN_W'(4050), 12'd4050, 50, 2, "v4050"};
      vecs[4] = '{'0,          12'd0,   50, 1,  "vzero"};
      vecs[5] = '{ones, RES_W'(ref_mod(ones)), 50, 50, "vones"};
      vecs[6] = '{one << 299, RES_W'(ref_mod(one << 299)), 50, 50, "vtopbit"};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", longint'(out_valid), 0);
      chk("rst out_res",   longint'(out_res),   0);
      chk("rst in_ready",  longint'(in_ready),  1);
      chk("rst busy",      longint'(busy),      0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].data, vecs[i].res,
                pick_lat(vecs[i].lat_base, vecs[i].lat_ee), vecs[i].name);
         @(posedge clk); #1;
         chk({vecs[i].name, " post in_ready"}, longint'(in_ready), 1);
         chk({vecs[i].name, " post out_valid"}, longint'(out_valid), 0);
      end

      // Back-pressure: result held for 7 cycles, in_valid pulses ignored
      out_ready = 1'b0;
      x = ones >> 7;
      run_op(x, RES_W'(ref_mod(x)), ref_lat(x), "hold");
      held = RES_W'(ref_mod(x));
      for (int c = 0; c < 7; c++) begin
         in_valid = (c % 2) == 0;
         in_data  = rand_opnd();
         @(posedge clk); #1;
         chk("hold out_valid", longint'(out_valid), 1);
         chk("hold out_res",   longint'(out_res),   longint'(held));
         chk("hold in_ready",  longint'(in_ready),  0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release in_ready",  longint'(in_ready),  1);
      chk("release out_valid", longint'(out_valid), 0);
      chk("release out_res",   longint'(out_res),   longint'(held));

      // Reset in RUN cycle 20 discards the operand
      in_valid = 1'b1;
      in_data  = ones;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (19) begin
         @(posedge clk); #1;
      end
      chk("pre-reset busy", longint'(busy), 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst out_valid", longint'(out_valid), 0);
      chk("midrst out_res",   longint'(out_res),   0);
      chk("midrst in_ready",  longint'(in_ready),  1);
      chk("midrst busy",      longint'(busy),      0);
      seen = 0;
      repeat (NCHUNK + 10) begin
         @(posedge clk); #1;
         if (out_valid || busy) seen++;
      end
      chk("no stale result", longint'(seen), 0);

      // Random operands, occasional back-pressure
      for (int i = 0; i < 400; i++) begin
         x = rand_opnd();
         out_ready = ($urandom_range(0, 3) != 0);
         run_op(x, RES_W'(ref_mod(x)), ref_lat(x), "rand");
         if (!out_ready) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk); #1;
            end
            chk("rand held", longint'(out_res), ref_mod(x));
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
